// File: rtl/cmp_pkg.sv
// Shared types and constants for the MSB-first serial magnitude comparator.
package cmp_pkg;

   localparam int CMP_WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } cmp_state_t;

endpackage

// File: rtl/serial_comparator.sv
// Bit-serial unsigned comparator: consumes one a/b bit pair per accepted cycle,
// MSB first, and presents gt/lt/eq with a valid/ready result handshake.
//
// state | meaning
// IDLE  | waiting for the first bit of an operand pair
// RUN   | bits 1..WIDTH-1 being consumed
// DONE  | result held until out_ready
module serial_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH = CMP_WIDTH_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic in_valid,
   output logic in_ready,
   input  logic a_bit,
   input  logic b_bit,
   output logic out_valid,
   input  logic out_ready,
   output logic gt,
   output logic lt,
   output logic eq,
   output logic decided
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   cmp_state_t      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            gt_q, gt_d;
   logic            lt_q, lt_d;
   logic            dec_q, dec_d;
   logic            accept;
   logic            last_bit;

   assign in_ready  = (state_q != DONE);
   assign out_valid = (state_q == DONE);
   assign accept    = in_valid && in_ready;
   assign last_bit  = (cnt_q == CW'(WIDTH - 1));

   assign gt      = gt_q;
   assign lt      = lt_q;
   assign decided = dec_q;
   assign eq      = !dec_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gt_d    = gt_q;
      lt_d    = lt_q;
      dec_d   = dec_q;

      if (clear) begin
         state_d = IDLE;
         cnt_d   = '0;
         gt_d    = 1'b0;
         lt_d    = 1'b0;
         dec_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE, RUN: begin
               if (accept) begin
                  // For WIDTH=1 last_bit is already true in IDLE, so we skip RUN.
                  if (last_bit) begin
                     state_d = DONE;
                     cnt_d   = '0;
                  end else begin
                     state_d = RUN;
                     cnt_d   = cnt_q + CW'(1);
                  end
                  // Only the first differing MSB-side bit decides the order.
                  if (!dec_q && (a_bit != b_bit)) begin
                     gt_d  = a_bit;
                     lt_d  = b_bit;
                     dec_d = 1'b1;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d = IDLE;
                  gt_d    = 1'b0;
                  lt_d    = 1'b0;
                  dec_d   = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
         dec_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gt_q    <= gt_d;
         lt_q    <= lt_d;
         dec_q   <= dec_d;
      end
   end

endmodule

// File: tb/tb_serial_comparator.sv
// Directed bench for serial_comparator at WIDTH=8 and WIDTH=2.
module tb_serial_comparator;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic clear8 = 1'b0, in_valid8 = 1'b0, a8 = 1'b0, b8 = 1'b0, out_ready8 = 1'b0;
   logic in_ready8, out_valid8, gt8, lt8, eq8, dec8;

   logic clear2 = 1'b0, in_valid2 = 1'b0, a2 = 1'b0, b2 = 1'b0, out_ready2 = 1'b0;
   logic in_ready2, out_valid2, gt2, lt2, eq2, dec2;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   serial_comparator #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .clear(clear8),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .a_bit(a8), .b_bit(b8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .gt(gt8), .lt(lt8), .eq(eq8), .decided(dec8)
   );

   serial_comparator #(.WIDTH(2)) u_dut2 (
      .clk(clk), .rst(rst), .clear(clear2),
      .in_valid(in_valid2), .in_ready(in_ready2),
      .a_bit(a2), .b_bit(b2),
      .out_valid(out_valid2), .out_ready(out_ready2),
      .gt(gt2), .lt(lt2), .eq(eq2), .decided(dec2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic stream8(input logic [7:0] a, input logic [7:0] b, input bit gaps);
      for (int i = 7; i >= 0; i--) begin
         a8 = a[i];
         b8 = b[i];
         in_valid8 = 1'b1;
         step();
         if (i == 1) check("w8_no_early_valid", {31'd0, out_valid8}, 32'd0);
         if (gaps) begin
            in_valid8 = 1'b0;
            step();
         end
      end
      in_valid8 = 1'b0;
   endtask

   task automatic result8(input string tag, input logic g, input logic l);
      check({tag, "_valid"}, {31'd0, out_valid8}, 32'd1);
      check({tag, "_gt"}, {31'd0, gt8}, {31'd0, g});
      check({tag, "_lt"}, {31'd0, lt8}, {31'd0, l});
      check({tag, "_eq"}, {31'd0, eq8}, {31'd0, !(g || l)});
      check({tag, "_ready0"}, {31'd0, in_ready8}, 32'd0);
   endtask

   task automatic release8();
      out_ready8 = 1'b1;
      step();
      out_ready8 = 1'b0;
      check("w8_release_idle", {30'd0, out_valid8, in_ready8}, 32'd1);
      check("w8_release_eq", {29'd0, gt8, lt8, eq8}, 32'd1);
   endtask

   task automatic pair2(input logic [1:0] a, input logic [1:0] b, input logic g, input logic l);
      for (int i = 1; i >= 0; i--) begin
         a2 = a[i];
         b2 = b[i];
         in_valid2 = 1'b1;
         step();
      end
      in_valid2 = 1'b0;
      check("w2_valid", {31'd0, out_valid2}, 32'd1);
      check("w2_gtlteq", {29'd0, gt2, lt2, eq2}, {29'd0, g, l, !(g || l)});
      out_ready2 = 1'b1;
      step();
      out_ready2 = 1'b0;
      check("w2_release", {30'd0, out_valid2, eq2}, 32'd1);
   endtask

   initial begin
      step();
      step();
      rst = 1'b0;
      step();
      check("rst_w8", {26'd0, in_ready8, out_valid8, gt8, lt8, eq8, dec8}, 32'b100010);
      check("rst_w2", {26'd0, in_ready2, out_valid2, gt2, lt2, eq2, dec2}, 32'b100010);

      // Equal operands, no gaps
      stream8(8'h5A, 8'h5A, 1'b0);
      result8("eq_5a", 1'b0, 1'b0);
      check("eq_5a_dec", {31'd0, dec8}, 32'd0);
      release8();

      // MSB decides immediately, remaining bits still consumed
      a8 = 1'b1; b8 = 1'b0; in_valid8 = 1'b1;
      step();
      check("gt_80_dec_first", {29'd0, dec8, gt8, lt8}, 32'b110);
      for (int i = 6; i >= 0; i--) begin
         a8 = 1'b0; b8 = 1'b1;
         step();
         if (i > 0) check("gt_80_consuming", {30'd0, in_ready8, gt8}, 32'b11);
      end
      in_valid8 = 1'b0;
      result8("gt_80", 1'b1, 1'b0);
      release8();

      // LSB decides, in_valid toggling
      stream8(8'h12, 8'h13, 1'b1);
      result8("lt_12", 1'b0, 1'b1);
      check("lt_12_dec", {31'd0, dec8}, 32'd1);

      // Hold result with out_ready low; offered bits must be ignored
      in_valid8 = 1'b1; a8 = 1'b1; b8 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("hold_stable", {27'd0, out_valid8, in_ready8, gt8, lt8, eq8}, 32'b10010);
      end
      in_valid8 = 1'b0;
      release8();

      // Abort mid-pair with clear (taking priority over in_valid), then fresh compare
      stream8(8'h00, 8'h00, 1'b0);
      release8();
      a8 = 1'b1; b8 = 1'b0; in_valid8 = 1'b1;
      step(); step();
      a8 = 1'b1; b8 = 1'b1;
      step();
      check("pre_clear_dec", {30'd0, dec8, gt8}, 32'b11);
      clear8 = 1'b1;
      step();
      clear8 = 1'b0;
      in_valid8 = 1'b0;
      check("clear_state", {27'd0, in_ready8, out_valid8, gt8, lt8, dec8}, 32'b10000);
      stream8(8'h01, 8'h01, 1'b0);
      result8("post_clear", 1'b0, 1'b0);
      release8();

      // Same abort with rst instead of clear
      a8 = 1'b1; b8 = 1'b0; in_valid8 = 1'b1;
      step(); step(); step();
      rst = 1'b1; clear8 = 1'b0;
      step();
      rst = 1'b0;
      in_valid8 = 1'b0;
      check("rst_midrun", {27'd0, in_ready8, out_valid8, gt8, lt8, dec8}, 32'b10000);
      stream8(8'h01, 8'h01, 1'b0);
      result8("post_rst", 1'b0, 1'b0);

      // Clear while in DONE
      clear8 = 1'b1; out_ready8 = 1'b0;
      step();
      clear8 = 1'b0;
      check("clear_done", {29'd0, in_ready8, out_valid8, eq8}, 32'b101);

      // WIDTH=2 vectors
      pair2(2'b00, 2'b10, 1'b0, 1'b1);
      pair2(2'b11, 2'b11, 1'b0, 1'b0);
      pair2(2'b01, 2'b00, 1'b1, 1'b0);
      pair2(2'b10, 2'b10, 1'b0, 1'b0);
      pair2(2'b00, 2'b00, 1'b0, 1'b0);
      pair2(2'b10, 2'b01, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
